// File: rtl/soc_system_led_walker_master.sv
// rtl/soc_system_led_walker_master.sv - LED PIO walking-one writer with read-back checking
// Periodically writes a rotating one-hot pattern over Avalon-MM, reads it back and counts mismatches.
module soc_system_led_walker_master #(
  parameter int LED_WIDTH = 4,
  parameter int TICKS     = 50000000,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clr,
  output logic [1:0]           avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  input  logic                 avm_waitrequest,
  output logic [LED_WIDTH-1:0] pattern,
  output logic [7:0]           mismatch_count,
  output logic                 err,
  output logic                 busy
);

  localparam int CW = $clog2(TICKS);
  localparam logic [CW-1:0] RELOAD = CW'(TICKS - 1);

  typedef enum logic [1:0] {
    WAIT_TICK = 2'd0,
    WRITE     = 2'd1,
    READ      = 2'd2,
    CHECK     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] pattern_q, pattern_d;
  logic [LED_WIDTH-1:0] rb_q, rb_d;
  logic [7:0]           mismatch_q, mismatch_d;
  logic                 err_q, err_d;
  logic                 write_q, write_d;
  logic                 read_q, read_d;
  logic                 busy_q, busy_d;

  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:LED_WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    rb_d       = rb_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    write_d    = write_q;
    read_d     = read_q;
    busy_d     = busy_q;

    unique case (state_q)
      WAIT_TICK: begin
        if (!enable) begin
          cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = WRITE;
          write_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          state_d = READ;
          write_d = 1'b0;
          read_d  = 1'b1;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          rb_d    = avm_readdata[LED_WIDTH-1:0];
          state_d = CHECK;
          read_d  = 1'b0;
        end
      end
      CHECK: begin
        if (rb_q != pattern_q) begin
          if (mismatch_q != 8'hFF) mismatch_d = mismatch_q + 8'd1;
          err_d = 1'b1;
        end
        pattern_d = (pattern_q << 1) | (pattern_q >> (LED_WIDTH - 1));
        cnt_d     = RELOAD;
        state_d   = WAIT_TICK;
        busy_d    = 1'b0;
      end
      default: state_d = WAIT_TICK;
    endcase

    // clr overrides a same-cycle mismatch update
    if (clr) begin
      mismatch_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= WAIT_TICK;
      cnt_q      <= RELOAD;
      pattern_q  <= LED_WIDTH'(1);
      rb_q       <= '0;
      mismatch_q <= '0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      rb_q       <= rb_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      write_q    <= write_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
    end
  end

  assign avm_address    = 2'(BASE_ADDR);
  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_writedata  = 32'(pattern_q);
  assign pattern        = pattern_q;
  assign mismatch_count = mismatch_q;
  assign err            = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_soc_system_led_walker_master.sv
// tb/tb_soc_system_led_walker_master.sv - randomized bench for the LED walker master
// Acts as the PIO slave and compares against a transaction-level model of the walk.
module tb_soc_system_led_walker_master;

  localparam int LW    = 4;
  localparam int TICKS = 4;
  localparam int BASE  = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clr;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest;
  logic [LW-1:0] pattern;
  logic [7:0]    mismatch_count;
  logic          err;
  logic          busy;

  soc_system_led_walker_master #(
    .LED_WIDTH(LW),
    .TICKS    (TICKS),
    .BASE_ADDR(BASE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clr            (clr),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .pattern        (pattern),
    .mismatch_count (mismatch_count),
    .err            (err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int ref_cyc  = 0;
  int next_gap = -1;

  // Reference model: number of completed updates, expected count and sticky flag.
  int n_upd   = 0;
  int exp_cnt = 0;
  bit exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [LW-1:0] exp_pattern();
    logic [LW-1:0] one;
    one = 1;
    return one << (n_upd % LW);
  endfunction

  task automatic model_reset();
    n_upd   = 0;
    exp_cnt = 0;
    exp_err = 0;
  endtask

  // One full write/read/check transaction; rmode 0=echo, 1=zero, 2=random.
  task automatic do_update(input int ws_w, input int ws_r, input int rmode,
                           input bit clr_at_check, input bit drop_en);
    int            waited;
    logic [31:0]   rd;
    logic [LW-1:0] ep;
    ep     = exp_pattern();
    waited = 0;
    while (avm_write !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (avm_write !== 1'b1) begin
      chk("write_timeout", 32'(avm_write), 32'd1);
      return;
    end
    if (next_gap >= 0) chk("gap", 32'(cyc - ref_cyc), 32'(next_gap));
    ref_cyc = cyc;
    chk("wdata", avm_writedata, 32'(ep));
    chk("addr", 32'(avm_address), 32'(BASE));
    chk("rw_excl_w", 32'(avm_read), 32'd0);
    chk("busy_w", 32'(busy), 32'd1);
    for (int i = 0; i < ws_w; i++) begin
      avm_waitrequest = 1'b1;
      tick();
      chk("w_hold", 32'(avm_write), 32'd1);
      chk("w_data_hold", avm_writedata, 32'(ep));
      chk("w_addr_hold", 32'(avm_address), 32'(BASE));
      chk("w_no_read", 32'(avm_read), 32'd0);
    end
    avm_waitrequest = 1'b0;
    tick();
    chk("w_drop", 32'(avm_write), 32'd0);
    chk("r_req", 32'(avm_read), 32'd1);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < ws_r; i++) begin
      avm_waitrequest = 1'b1;
      avm_readdata    = $urandom;
      tick();
      chk("r_hold", 32'(avm_read), 32'd1);
      chk("r_addr_hold", 32'(avm_address), 32'(BASE));
      chk("r_no_write", 32'(avm_write), 32'd0);
    end
    rd = $urandom;
    if (rmode == 0) rd[LW-1:0] = ep;
    else if (rmode == 1) rd = 32'd0;
    avm_readdata    = rd;
    avm_waitrequest = 1'b0;
    tick();
    chk("r_drop", 32'(avm_read), 32'd0);
    chk("busy_chk", 32'(busy), 32'd1);
    avm_readdata = $urandom;
    if (rd[LW-1:0] != ep) begin
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      exp_err = 1'b1;
    end
    if (clr_at_check) begin
      clr     = 1'b1;
      exp_cnt = 0;
      exp_err = 1'b0;
    end
    tick();
    clr = 1'b0;
    n_upd++;
    next_gap = TICKS + 3 + ws_w + ws_r;
    chk("count", 32'(mismatch_count), 32'(exp_cnt));
    chk("err", 32'(err), 32'(exp_err));
    chk("pattern", 32'(pattern), 32'(exp_pattern()));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr     = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    chk("clr_count", 32'(mismatch_count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
  endtask

  task automatic count_requests(input int ncyc, output int reqs);
    reqs = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (avm_write !== 1'b0 || avm_read !== 1'b0) reqs++;
    end
  endtask

  initial begin
    int reqs;
    int waited;
    reset_n         = 1'b0;
    enable          = 1'b0;
    clr             = 1'b0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_pattern", 32'(pattern), 32'd1);
    chk("rst_wdata", avm_writedata, 32'd1);
    chk("rst_count", 32'(mismatch_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    model_reset();

    // Disabled from reset: no traffic at all
    count_requests(100, reqs);
    chk("disabled_reqs", 32'(reqs), 32'd0);
    chk("disabled_pattern", 32'(pattern), 32'd1);
    enable   = 1'b1;
    ref_cyc  = cyc;
    next_gap = TICKS;

    // Plain walk with echoing slave: 1,2,4,8,1
    for (int i = 0; i < 5; i++) do_update(0, 0, 0, 1'b0, 1'b0);

    // Wait states on both phases
    for (int i = 0; i < 3; i++) do_update(3, 3, 0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++)
      do_update($urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 0) ? 0 : 2,
                ($urandom_range(0, 7) == 0), 1'b0);

    // Mismatch accumulation, then clear
    pulse_clr();
    for (int i = 0; i < 3; i++) do_update(0, 0, 1, 1'b0, 1'b0);
    chk("mm3_count", 32'(mismatch_count), 32'd3);
    chk("mm3_err", 32'(err), 32'd1);
    pulse_clr();

    // clr colliding with a mismatching check
    do_update(0, 0, 1, 1'b0, 1'b0);
    do_update(0, 0, 1, 1'b1, 1'b0);
    chk("collide_count", 32'(mismatch_count), 32'd0);
    chk("collide_err", 32'(err), 32'd0);

    // Saturation
    for (int i = 0; i < 300; i++) do_update(0, 0, 1, 1'b0, 1'b0);
    chk("sat_count", 32'(mismatch_count), 32'd255);
    chk("sat_err", 32'(err), 32'd1);

    // enable dropped mid-read
    do_update(1, 2, 0, 1'b0, 1'b1);
    count_requests(60, reqs);
    chk("drop_en_reqs", 32'(reqs), 32'd0);
    chk("drop_en_pattern", 32'(pattern), 32'(exp_pattern()));
    enable   = 1'b1;
    ref_cyc  = cyc;
    next_gap = TICKS;
    do_update(0, 0, 0, 1'b0, 1'b0);

    // Reset during a stalled write
    waited = 0;
    while (avm_write !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    chk("mid_write_seen", 32'(avm_write), 32'd1);
    avm_waitrequest = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_write", 32'(avm_write), 32'd0);
    chk("mid_rst_pattern", 32'(pattern), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(mismatch_count), 32'd0);
    reset_n         = 1'b1;
    avm_waitrequest = 1'b0;
    model_reset();
    ref_cyc  = cyc;
    next_gap = TICKS;
    do_update(0, 0, 0, 1'b0, 1'b0);
    do_update(0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_system_led_walker_master.md
# soc_system_led_walker_master

Avalon-MM initiator that drives the LED PIO output register from the fabric side. It periodically writes a walking-one pattern to the PIO data register, reads it back over the same port, and counts read-back mismatches. It sits in the soc_system fabric as an alternative master to the HPS bridge. It is used for board bring-up and for a self-checking LED interconnect test.

## Interface

Parameters:
- `LED_WIDTH`, default 4: pattern width; the low bits of `writedata`/`readdata`.
- `TICKS`, default 50000000: clocks between pattern updates; legal range ≥ 2.
- `BASE_ADDR`, default 0: word address of the PIO data register, driven on `avm_address`.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run control; when 0, the tick timer holds at reload.
- `clr`  in  1  one-cycle pulse; clears `mismatch_count` and `err`.
- `avm_address`  out  2  constant `BASE_ADDR`.
- `avm_read`  out  1  read request.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  32  `{zeros, pattern}`.
- `avm_readdata`  in  32  read data; valid in a cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest`  in  1  slave stall.
- `pattern`  out  LED_WIDTH  current pattern.
- `mismatch_count`  out  8  saturating count of read-back mismatches.
- `err`  out  1  sticky mismatch flag.
- `busy`  out  1  high in WRITE, READ and CHECK.

## Operation

- FSM states: WAIT_TICK, WRITE, READ, CHECK.
- **WAIT_TICK**:
  - The down-counter `cnt` decrements while `enable`=1 and `cnt`≠0.
  - While `enable`=0, `cnt` reloads to `TICKS-1`.
  - When `enable`=1 and `cnt`=0, the next state is WRITE.
- **WRITE**:
  - `avm_write`=1 and `avm_writedata`={0, `pattern`}.
  - Both are held stable while `avm_waitrequest`=1.
  - When `avm_waitrequest`=0, the next state is READ and `avm_write` drops.
- **READ**:
  - `avm_read`=1, held stable while `avm_waitrequest`=1.
  - When `avm_waitrequest`=0, capture `avm_readdata[LED_WIDTH-1:0]` into `rb`; the next state is CHECK.
- **CHECK**:
  - If `rb`≠`pattern`: `mismatch_count` += 1, saturating at 255, and `err` is set.
  - `pattern` rotates left by one: MSB wraps to bit 0, so 1000→0001.
  - `cnt` reloads to `TICKS-1`; the next state is WAIT_TICK.
- `enable` deasserted during WRITE/READ/CHECK has no effect. The transaction completes, and the timer holds only after the return to WAIT_TICK.
- `avm_read` and `avm_write` are never high in the same cycle.
- `clr` applies in any state. If `clr` coincides with a CHECK mismatch, `clr` wins: count=0 and `err`=0.
- Reset values, applied on the first rising edge with `reset_n`=0:
  - state = WAIT_TICK, `cnt`=`TICKS-1`.
  - `pattern`=1, `avm_writedata`=1.
  - `avm_read`=0, `avm_write`=0.
  - `mismatch_count`=0, `err`=0, `busy`=0.
- Reset mid-transaction aborts it: the request drops at that edge.

## Timing

- All outputs are registered.
- The cycle after WAIT_TICK sees `cnt`=0 with `enable`=1, `avm_write` asserts.
- With zero wait states:
  - WRITE: 1 cycle; READ: 1 cycle; CHECK: 1 cycle.
  - `pattern` updates at the end of CHECK.
  - Update period = `TICKS`+3 cycles.
- Each wait-state cycle extends WRITE or READ by one cycle.
- `mismatch_count` and `err` are visible the cycle after CHECK.
- `busy` rises with `avm_write` and falls when the state returns to WAIT_TICK.

## Test plan

- **Reset and walk**: TICKS=4, `enable`=1, slave echoes the written data with no wait states.
  - Writedata sequence 1,2,4,8,1.
  - `mismatch_count`=0.
  - Writes spaced exactly 7 cycles apart.
- **Wait states**: slave holds `avm_waitrequest`=1 for 3 cycles on each write and each read.
  - Address, data and request are stable throughout.
  - Period is 13 cycles.
- **Mismatch**: slave returns 0 on every read.
  - After 3 updates, `mismatch_count`=3 and `err`=1.
  - A `clr` pulse then gives count=0 and `err`=0.
  - After 300 updates, count saturates at 255.
- **clr collision**: `clr` pulses in the same cycle as a mismatching CHECK → count=0, `err`=0.
- **enable gating**:
  - `enable`=0 from reset: no request for 100 cycles, `pattern`=1.
  - `enable` dropped mid-READ: the read completes, `pattern` advances once, then no further requests.
- **Reset mid-transaction**: `reset_n` low during a stalled WRITE.
  - `avm_write`=0 and `pattern`=1 on the next edge.
  - After release, the first write occurs TICKS cycles later.
